ahb_arbiter_rr: RTL



---
 rtl/ahb_arbiter_rr.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_rr
// Description : AHB-Lite multi-master arbiter with fixed-priority or
//               round-robin selection, burst/lock hold, and address/data muxes.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RR_MODE        = 1,
  parameter int DEFAULT_MASTER = 0,
  localparam int c_MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_MASTERS-1:0]        m_busreq,
  input  logic [NUM_MASTERS-1:0]        m_hlock,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
  input  logic [NUM_MASTERS*2-1:0]      m_htrans,
  input  logic [NUM_MASTERS*3-1:0]      m_hburst,
  input  logic [NUM_MASTERS*3-1:0]      m_hsize,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
  input  logic                          hready,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic [c_MW-1:0]               s_hmaster,
  output logic                          s_hmaster_lock,
  output logic [ADDR_W-1:0]             s_haddr,
  output logic [1:0]                    s_htrans,
  output logic [2:0]                    s_hburst,
  output logic [2:0]                    s_hsize,
  output logic                          s_hwrite,
  output logic [DATA_W-1:0]             s_hwdata
);

  localparam logic [c_MW:0]   c_NM       = (c_MW+1)'(NUM_MASTERS);
  localparam logic [c_MW-1:0] c_DEF      = c_MW'(DEFAULT_MASTER);

  localparam logic [1:0]      c_IDLE     = 2'b00;
  localparam logic [1:0]      c_BUSY     = 2'b01;
  localparam logic [1:0]      c_NONSEQ   = 2'b10;
  localparam logic [1:0]      c_SEQ      = 2'b11;

  localparam logic [1:0]      c_ST_ARB    = 2'd0;
  localparam logic [1:0]      c_ST_BURST  = 2'd1;
  localparam logic [1:0]      c_ST_LOCKED = 2'd2;

  logic [c_MW-1:0]   r_grant_idx;
  logic [c_MW-1:0]   r_addr_owner;
  logic [c_MW-1:0]   r_data_owner;
  logic [c_MW-1:0]   r_rr_ptr;
  logic [4:0]        r_beats_left;
  logic              r_lock_hold;
  logic              r_hmaster_lock;
  logic [1:0]        r_state;

  logic [1:0]        w_state_nxt;
  logic [c_MW-1:0]   w_arb_idx;
  logic [c_MW:0]     w_scan;
  logic              w_hold;
  logic              w_final_seq;
  logic [4:0]        w_beats_nxt;
  logic              w_lock_nxt;

  logic [ADDR_W-1:0] w_haddr_arr  [NUM_MASTERS];
  logic [1:0]        w_htrans_arr [NUM_MASTERS];
  logic [2:0]        w_hburst_arr [NUM_MASTERS];
  logic [2:0]        w_hsize_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] w_hwdata_arr [NUM_MASTERS];

  generate
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_master
      assign w_haddr_arr[g]  = m_haddr[g*ADDR_W +: ADDR_W];
      assign w_htrans_arr[g] = m_htrans[g*2 +: 2];
      assign w_hburst_arr[g] = m_hburst[g*3 +: 3];
      assign w_hsize_arr[g]  = m_hsize[g*3 +: 3];
      assign w_hwdata_arr[g] = m_hwdata[g*DATA_W +: DATA_W];
      assign hgrant[g]       = (r_grant_idx == c_MW'(g));
    end
  endgenerate

  assign s_haddr        = w_haddr_arr[r_addr_owner];
  assign s_htrans       = w_htrans_arr[r_addr_owner];
  assign s_hburst       = w_hburst_arr[r_addr_owner];
  assign s_hsize        = w_hsize_arr[r_addr_owner];
  assign s_hwrite       = m_hwrite[r_addr_owner];
  assign s_hwdata       = w_hwdata_arr[r_data_owner];
  assign s_hmaster      = r_addr_owner;
  assign s_hmaster_lock = r_hmaster_lock;

  // Loops run downward so the last (winning) assignment is the nearest candidate.
  always_comb begin
    w_arb_idx = c_DEF;
    w_scan    = '0;
    if (RR_MODE == 0) begin
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
        if (m_busreq[i]) w_arb_idx = c_MW'(i);
      end
    end else begin
      for (int off = NUM_MASTERS; off >= 1; off--) begin
        w_scan = {1'b0, r_rr_ptr} + (c_MW+1)'(off);
        if (w_scan >= c_NM) w_scan = w_scan - c_NM;
        if (m_busreq[w_scan[c_MW-1:0]]) w_arb_idx = w_scan[c_MW-1:0];
      end
    end
  end

  // The final SEQ of a fixed burst releases the hold on the edge that accepts
  // it, so the next owner sees its grant one cycle after the last address.
  assign w_final_seq = (r_beats_left == 5'd1) && (s_htrans == c_SEQ);

  always_comb begin
    w_beats_nxt = r_beats_left;
    case (s_htrans)
      c_NONSEQ: begin
        case (s_hburst)
          3'b010, 3'b011: w_beats_nxt = 5'd3;
          3'b100, 3'b101: w_beats_nxt = 5'd7;
          3'b110, 3'b111: w_beats_nxt = 5'd15;
          default:        w_beats_nxt = 5'd0;
        endcase
      end
      c_SEQ: begin
        if (r_beats_left != 5'd0) w_beats_nxt = r_beats_left - 5'd1;
      end
      c_BUSY:  w_beats_nxt = r_beats_left;
      c_IDLE:  w_beats_nxt = 5'd0;
      default: w_beats_nxt = 5'd0;
    endcase

    if (!w_hold) begin
      w_lock_nxt = m_hlock[w_arb_idx] & m_busreq[w_arb_idx];
    end else if (!m_hlock[r_grant_idx]) begin
      w_lock_nxt = 1'b0;
    end else begin
      w_lock_nxt = r_lock_hold;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset) begin
      r_state <= c_ST_ARB;
    end else if (hready) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = c_ST_ARB;
    if (w_lock_nxt) begin
      w_state_nxt = c_ST_LOCKED;
    end else if (w_beats_nxt != 5'd0) begin
      w_state_nxt = c_ST_BURST;
    end
  end

  always_comb begin
    w_hold = 1'b0;
    case (r_state)
      c_ST_LOCKED: w_hold = 1'b1;
      c_ST_BURST:  w_hold = ~w_final_seq;
      default:     w_hold = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset) begin
      r_grant_idx    <= c_DEF;
      r_addr_owner   <= c_DEF;
      r_data_owner   <= c_DEF;
      r_rr_ptr       <= c_DEF;
      r_beats_left   <= 5'd0;
      r_lock_hold    <= 1'b0;
      r_hmaster_lock <= 1'b0;
    end else if (hready) begin
      if (!w_hold) begin
        r_grant_idx <= w_arb_idx;
        if (m_busreq[w_arb_idx]) r_rr_ptr <= w_arb_idx;
      end
      r_lock_hold    <= w_lock_nxt;
      r_beats_left   <= w_beats_nxt;
      r_addr_owner   <= r_grant_idx;
      r_data_owner   <= r_addr_owner;
      r_hmaster_lock <= m_hlock[r_grant_idx];
    end
  end

  a_grant_onehot: assert property (@(posedge hclk) disable iff (!hreset) $onehot(hgrant));
  a_master_range: assert property (@(posedge hclk) disable iff (!hreset) ({1'b0, s_hmaster} < c_NM));

endmodule
`default_nettype wire
